// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin scheduler sharing one 5-byte 8-n-1 UART transmitter among N_REQ
// requesters. One requester is granted at a time, and its 40-bit frame is latched
// onto byte0..byte4. A one-cycle send_ready pulse starts the transmitter. The
// bytes are then held for TX_CYCLES clocks, after which a one-cycle ack is
// returned to the winner.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   TX_CYCLES  clocks the bytes are held after send_ready (>= 52)
//   ID_W       width of grant_id (>= ceil(log2(N_REQ)))
//
// Ports
//   clk_19k2    in   baud clock, the only clock
//   rst         in   synchronous active-high reset
//   req         in   per-requester request level, held until ack
//   frame_data  in   requester i frame at [40*i+39:40*i], byte0 in the top byte
//   ack         out  one-cycle completion pulse to the granted requester
//   busy        out  high from grant until the cycle after ack
//   grant_id    out  index of the current or most recent winner
//   send_ready  out  one-cycle start pulse to the transmitter
//   byte0..4    out  frame bytes to the transmitter, byte0 sent first
//
// All outputs are registered, so no combinational path runs from req or
// frame_data to any output.

module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TX_CYCLES = 56,
    parameter int unsigned ID_W      = 2
) (
    input  logic                  clk_19k2,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [40*N_REQ-1:0]   frame_data,
    output logic [N_REQ-1:0]      ack,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  send_ready,
    output logic [7:0]            byte0,
    output logic [7:0]            byte1,
    output logic [7:0]            byte2,
    output logic [7:0]            byte3,
    output logic [7:0]            byte4
);

    localparam int unsigned CNT_W = $clog2(TX_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    // Winner selection and the data needed to latch it
    logic              any_req;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   next_rr;
    logic [39:0]       win_frame;
    logic [N_REQ-1:0]  gid_onehot;

    assign any_req = |req;

    // Two candidates are tracked in one descending scan: the lowest set bit at
    // or above rr_ptr, and the lowest set bit overall. The first one wins; the
    // second covers the wrap-around case when nothing at or above rr_ptr is set.
    always_comb begin
        logic            hi_found;
        logic [ID_W-1:0] hi_idx;
        logic [ID_W-1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    assign next_rr = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        win_frame = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_frame = frame_data[40*i +: 40];
            end
        end
    end

    always_comb begin
        gid_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gid_onehot[i] = (grant_id == ID_W'(i));
        end
    end

    // Control FSM with registered outputs. byte0..4 and grant_id are written
    // only on the IDLE->FIRE edge, so they stay stable for the whole
    // transmission and keep their values while idle.
    always_ff @(posedge clk_19k2) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            send_ready <= 1'b0;
            byte0      <= 8'h00;
            byte1      <= 8'h00;
            byte2      <= 8'h00;
            byte3      <= 8'h00;
            byte4      <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        byte0      <= win_frame[39:32];
                        byte1      <= win_frame[31:24];
                        byte2      <= win_frame[23:16];
                        byte3      <= win_frame[15:8];
                        byte4      <= win_frame[7:0];
                        grant_id   <= win_idx;
                        busy       <= 1'b1;
                        rr_ptr_q   <= next_rr;
                        // Pulse is set here so it is high during FIRE only
                        send_ready <= 1'b1;
                        state_q    <= StFire;
                    end
                end
                StFire: begin
                    send_ready <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TX_CYCLES - 1)) begin
                        // Set on entry so ack is high during DONE only
                        ack     <= gid_onehot;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
